// File: rtl/adaptive_binarization.sv
// Luma binarizer: fixed, frame-mean adaptive or window threshold, 1-cycle latency.
// Frame mean is produced by a bit-serial restoring divider that runs during vertical blanking.
module adaptive_binarization #(
  parameter int DW          = 8,
  parameter int CNT_W       = 20,
  parameter int DEFAULT_THR = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_invert,
  input  logic [DW-1:0] cfg_thr,
  input  logic [DW-1:0] cfg_thr_hi,
  input  logic [DW:0]   cfg_offset,
  input  logic          pre_vsync,
  input  logic          pre_hsync,
  input  logic          pre_de,
  input  logic [DW-1:0] luminance,
  output logic          post_vsync,
  output logic          post_hsync,
  output logic          post_de,
  output logic          monoc,
  output logic [DW-1:0] thr_active,
  output logic          stat_valid
);
  localparam int SW = DW + CNT_W;
  localparam int BW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         r_state, w_next;
  logic [1:0]     r_mode;
  logic           r_invert;
  logic [DW-1:0]  r_hi;
  logic [DW-1:0]  r_mean;
  logic           r_mean_vld;
  logic [SW-1:0]  r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]  r_quo;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_dvs;
  logic [BW-1:0]  r_bit;

  logic           w_vs_rise, w_vs_fall, w_start, w_hit, w_ge;
  logic [DW+1:0]  w_adp_sum;
  logic [DW-1:0]  w_thr_adp;
  logic [CNT_W:0] w_rem_sh, w_diff;

  // post_vsync doubles as the previous-cycle vsync for edge detection
  assign w_vs_rise = pre_vsync & ~post_vsync;
  assign w_vs_fall = ~pre_vsync & post_vsync;
  assign w_start   = w_vs_rise && (r_cnt != '0);

  assign w_adp_sum = $signed({2'b00, r_mean}) + $signed({cfg_offset[DW], cfg_offset});

  always_comb begin
    w_thr_adp = w_adp_sum[DW-1:0];
    if (!r_mean_vld)       w_thr_adp = DW'(DEFAULT_THR);
    else if (w_adp_sum[DW+1]) w_thr_adp = '0;
    else if (w_adp_sum[DW])   w_thr_adp = '1;
  end

  // in window mode thr_active holds the shadowed low bound
  always_comb begin
    case (r_mode)
      2'd2:    w_hit = (luminance >= thr_active) && (luminance <= r_hi);
      default: w_hit = luminance > thr_active;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_vsync <= 1'b0;
      post_hsync <= 1'b0;
      post_de    <= 1'b0;
      monoc      <= 1'b0;
      r_mode     <= '0;
      r_invert   <= 1'b0;
      r_hi       <= '0;
      thr_active <= DW'(DEFAULT_THR);
    end else begin
      post_vsync <= pre_vsync;
      post_hsync <= pre_hsync;
      post_de    <= pre_de;
      monoc      <= pre_de & (w_hit ^ r_invert);
      if (w_vs_fall) begin
        r_mode     <= cfg_mode;
        r_invert   <= cfg_invert;
        r_hi       <= cfg_thr_hi;
        thr_active <= (cfg_mode == 2'd1) ? w_thr_adp : cfg_thr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_vs_rise) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (pre_de && (r_cnt != '1)) begin
      r_sum <= r_sum + {{CNT_W{1'b0}}, luminance};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // remainder stays below the divisor, so the top bit of the difference is the borrow
  assign w_rem_sh = {r_rem, r_quo[SW-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_bit      <= '0;
      r_mean     <= DW'(DEFAULT_THR);
      r_mean_vld <= 1'b0;
    end else begin
      if (w_start) begin
        r_quo <= r_sum;
        r_rem <= '0;
        r_dvs <= r_cnt;
        r_bit <= '0;
      end else if (r_state == DIV) begin
        r_quo <= {r_quo[SW-2:0], w_ge};
        r_rem <= w_ge ? w_diff[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
        r_bit <= r_bit + 1'b1;
      end
      if (r_state == DONE) begin
        r_mean     <= (|r_quo[SW-1:DW]) ? '1 : r_quo[DW-1:0];
        r_mean_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_vs_rise) begin
      w_next = w_start ? DIV : IDLE;
    end else begin
      case (r_state)
        DIV:     if (r_bit == BW'(SW - 1)) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    stat_valid = (r_state == DONE);
  end
endmodule

// File: tb/tb_adaptive_binarization.sv
// Scoreboard bench for adaptive_binarization: a behavioural model predicts every output cycle,
// expectations are queued at drive time and compared one cycle later.
module tb_adaptive_binarization;
  localparam int DW = 8, CNT_W = 20, DEF = 64, SW = DW + CNT_W;

  logic          clk = 1'b0, rst = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic          cfg_invert = 1'b0;
  logic [DW-1:0] cfg_thr = 8'd64, cfg_thr_hi = 8'd0;
  logic [DW:0]   cfg_offset = 9'd0;
  logic          pre_vsync = 1'b0, pre_hsync = 1'b0, pre_de = 1'b0;
  logic [DW-1:0] luminance = 8'd0;
  logic          post_vsync, post_hsync, post_de, monoc, stat_valid;
  logic [DW-1:0] thr_active;

  adaptive_binarization #(.DW(DW), .CNT_W(CNT_W), .DEFAULT_THR(DEF)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_invert(cfg_invert),
    .cfg_thr(cfg_thr), .cfg_thr_hi(cfg_thr_hi), .cfg_offset(cfg_offset),
    .pre_vsync(pre_vsync), .pre_hsync(pre_hsync), .pre_de(pre_de), .luminance(luminance),
    .post_vsync(post_vsync), .post_hsync(post_hsync), .post_de(post_de), .monoc(monoc),
    .thr_active(thr_active), .stat_valid(stat_valid));

  always #5 clk = ~clk;

  typedef struct packed {
    logic vs, hs, de, mono, sv;
    logic [DW-1:0] thr;
  } exp_t;

  exp_t  sbq[$];
  string tq[$];
  int    total = 0, bad = 0;

  // model state
  int    m_mode, m_inv, m_lo, m_hi, m_thr, m_mean, m_vld, m_pend, m_cd, m_cnt, m_pvs;
  longint m_sum;

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got{vs,hs,de,mono,sv,thr}=%h exp=%h", tag, got, exp);
    end
  endtask

  exp_t  mon_e;
  string mon_t;
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_t = tq.pop_front();
      chk(mon_t, {post_vsync, post_hsync, post_de, monoc, stat_valid, thr_active}, mon_e);
    end
  end

  task automatic model_reset();
    m_mode = 0; m_inv = 0; m_lo = 0; m_hi = 0; m_thr = DEF; m_mean = DEF; m_vld = 0;
    m_pend = 0; m_cd = 0; m_sum = 0; m_cnt = 0; m_pvs = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit h, input bit d, input int y,
                      input string tag);
    exp_t e;
    bit   hit, fall, rise;
    int   t;
    @(negedge clk);
    rst = r; pre_vsync = v; pre_hsync = h; pre_de = d; luminance = 8'(y);
    if (r) begin
      model_reset();
      e = '{vs: 1'b0, hs: 1'b0, de: 1'b0, mono: 1'b0, sv: 1'b0, thr: 8'(DEF)};
    end else begin
      if (m_mode == 2) hit = (y >= m_lo) && (y <= m_hi);
      else             hit = y > m_thr;
      e.vs = v; e.hs = h; e.de = d;
      e.mono = d & (hit ^ m_inv[0]);
      fall = m_pvs && !v;
      rise = !m_pvs && v;
      if (fall) begin
        m_mode = cfg_mode; m_inv = cfg_invert; m_lo = cfg_thr; m_hi = cfg_thr_hi;
        if (cfg_mode == 2'd1) begin
          if (m_vld == 0) m_thr = DEF;
          else begin
            t = m_mean + $signed(cfg_offset);
            m_thr = (t < 0) ? 0 : (t > 255) ? 255 : t;
          end
        end else m_thr = cfg_thr;
      end
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin m_mean = m_pend; m_vld = 1; end
      end
      if (rise) begin
        if (m_cnt != 0) begin
          m_pend = int'(m_sum / m_cnt);
          if (m_pend > 255) m_pend = 255;
          m_cd = SW + 1;
        end else m_cd = 0;
        m_sum = 0; m_cnt = 0;
      end else if (d) begin
        m_sum += y; m_cnt++;
      end
      e.sv  = (m_cd == 1);
      e.thr = 8'(m_thr);
      m_pvs = v;
    end
    sbq.push_back(e);
    tq.push_back(tag);
  endtask

  // kind 0: constant base, kind 1: ramp from base; chg>=0 rewrites cfg_thr mid-frame
  task automatic frame(input int w, input int h, input int kind, input int base, input int vb,
                       input int chg, input int rst_at, input string tag);
    if (h == 0) repeat (4) step(0, 0, 0, 0, 0, tag);
    for (int l = 0; l < h; l++) begin
      if (l == 1 && chg >= 0) cfg_thr = 8'(chg);
      repeat (2) step(0, 0, 0, 0, 0, tag);
      for (int p = 0; p < w; p++)
        step(0, 0, 1, 1, (kind == 0) ? base : ((base + l * w + p) & 255), tag);
    end
    for (int b = 0; b < vb; b++) step(b == rst_at, 1, 0, 0, 0, tag);
  endtask

  initial begin
    model_reset();
    repeat (3) step(1, 0, 0, 0, 0, "reset");
    repeat (4) step(0, 1, 0, 0, 0, "vblank");
    frame(16, 16, 1, 0, 40, -1, -1, "m0_ramp");
    cfg_mode = 2'd1;
    frame(16, 4, 0, 100, 40, -1, -1, "m1_frameA");
    frame(16, 4, 1, 90, 40, -1, -1, "m1_thr100");
    cfg_offset = 9'd20;
    frame(16, 4, 0, 250, 40, -1, -1, "m1_mean250");
    frame(16, 4, 0, 5, 40, -1, -1, "m1_sat_hi");
    cfg_offset = -9'sd20;
    frame(16, 4, 1, 0, 40, -1, -1, "m1_sat_lo");
    cfg_mode = 2'd2; cfg_thr = 8'd50; cfg_thr_hi = 8'd60; cfg_invert = 1'b1;
    frame(16, 4, 1, 40, 40, -1, -1, "m2_win");
    cfg_thr = 8'd70;
    frame(16, 4, 1, 40, 40, -1, -1, "m2_lo_gt_hi");
    cfg_mode = 2'd3; cfg_thr = 8'd64; cfg_invert = 1'b0;
    frame(16, 16, 1, 0, 40, 200, -1, "m3_midchg");
    frame(16, 4, 1, 180, 40, -1, -1, "m3_next");
    cfg_mode = 2'd1; cfg_offset = 9'd0;
    frame(0, 0, 0, 0, 40, -1, -1, "zero_de");
    frame(16, 4, 1, 0, 40, -1, -1, "after_zero");
    frame(16, 4, 1, 0, 3, -1, -1, "retrig_a");
    frame(2, 1, 0, 30, 40, -1, -1, "retrig_b");
    frame(16, 4, 1, 20, 40, -1, -1, "after_retrig");
    frame(16, 4, 0, 80, 40, -1, 10, "rst_div");
    frame(16, 4, 1, 50, 20, -1, -1, "post_rst");
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) chk("drain", 13'(sbq.size()), 13'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
